// File: rtl/sipo_regroup_if.sv
// sipo_regroup_if: serial sample input and assembled-word
// output handshakes for the arctan2 return-path regrouper.
interface sipo_regroup_if #(
  parameter int DIN_WIDTH = 16,
  parameter int PARALLEL  = 4
);
  logic [DIN_WIDTH-1:0]          din;
  logic                          din_valid;
  logic                          din_ready;
  logic [PARALLEL*DIN_WIDTH-1:0] dout;
  logic                          dout_valid;
  logic                          dout_ready;
  logic                          fifo_full;
  logic                          overflow;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid,
    input  fifo_full, overflow
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid,
    output fifo_full, overflow
  );
endinterface

// File: rtl/sipo_regroup.sv
// sipo_regroup: packs PARALLEL serial samples into one word
// and buffers words in a FWFT FIFO. SIPO_REGROUP_FLUSH_EN adds flush.
module sipo_regroup #(
  parameter int DIN_WIDTH  = 16,
  parameter int PARALLEL   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
`ifdef SIPO_REGROUP_FLUSH_EN
  input logic flush,
`endif
  sipo_regroup_if.slave bus
);
  localparam int W     = PARALLEL * DIN_WIDTH;
  localparam int CW    = $clog2(PARALLEL);
  localparam int DEPTH = 1 << FIFO_DEPTH;
  localparam logic [CW-1:0] LAST = CW'(PARALLEL - 1);
  localparam logic [CW:0]   PF   = (CW+1)'(PARALLEL);
  localparam logic [FIFO_DEPTH:0] OFULL =
    (FIFO_DEPTH+1)'(DEPTH);

  logic [CW-1:0]         cnt;
  logic [W-1:0]          asm_q;
  logic [W-1:0]          word;
  logic [W-1:0]          dout_q;
  logic [W-1:0]          mem [DEPTH];
  logic [FIFO_DEPTH-1:0] rd_ptr;
  logic [FIFO_DEPTH-1:0] wr_ptr;
  logic [FIFO_DEPTH-1:0] rd_nx;
  logic [FIFO_DEPTH:0]   occ;
  logic [FIFO_DEPTH:0]   occ_nx;
  logic                  full_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [CW:0]           filled;

  assign bus.din_ready  = !(full_q && cnt == LAST);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.fifo_full  = full_q;
  assign bus.overflow   = ovf_q;

  assign accept = bus.din_valid && bus.din_ready;
  assign pop    = valid_q && bus.dout_ready;
  assign filled = {1'b0, cnt} + (CW+1)'(accept);

`ifdef SIPO_REGROUP_FLUSH_EN
  logic part;
  assign part = flush && filled != '0 && filled != PF;
  assign push = filled == PF || (part && !full_q);
  assign drop = part && full_q;
`else
  assign push = filled == PF;
  assign drop = 1'b0;
`endif

  // lanes past the fill point are zeroed; asm_q keeps stale lanes
  always_comb begin
    word = '0;
    for (int k = 0; k < PARALLEL; k++) begin
      if ((CW+1)'(k) < filled) begin
        word[k*DIN_WIDTH +: DIN_WIDTH] =
          (accept && CW'(k) == cnt) ? bus.din
                                    : asm_q[k*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  assign rd_nx  = rd_ptr + FIFO_DEPTH'(pop);
  assign occ_nx = occ + (FIFO_DEPTH+1)'(push)
                      - (FIFO_DEPTH+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      asm_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept)
        asm_q[cnt*DIN_WIDTH +: DIN_WIDTH] <= bus.din;
      if (push || drop)
        cnt <= '0;
      else if (accept)
        cnt <= cnt + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_nx;
      occ     <= occ_nx;
      full_q  <= occ_nx == OFULL;
      valid_q <= occ_nx != '0;
      // a word pushed into an empty slot is the new head
      if (occ_nx != '0)
        dout_q <= (push && rd_nx == wr_ptr) ? word
                                            : mem[rd_nx];
      if ((bus.din_valid && !bus.din_ready) || drop)
        ovf_q <= 1'b1;
    end
  end
endmodule
